// File: rtl/id_pkg.sv
// ============================================================================
// Module : id_pkg
// Desc   : Opcodes, bundle widths and control encodings for the ID stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  // wb = {RegWrite, MemtoReg}; m = {Branch, MemRead, MemWrite}; ex = {RegDst, ALUOp, ALUSrc}
  localparam logic [WB_W-1:0] WB_RTYPE = 2'b10;
  localparam logic [WB_W-1:0] WB_LW    = 2'b11;
  localparam logic [WB_W-1:0] WB_SW    = 2'b00;
  localparam logic [WB_W-1:0] WB_BEQ   = 2'b00;
  localparam logic [WB_W-1:0] WB_NOP   = 2'b00;

  localparam logic [M_W-1:0]  M_RTYPE  = 3'b000;
  localparam logic [M_W-1:0]  M_LW     = 3'b010;
  localparam logic [M_W-1:0]  M_SW     = 3'b001;
  localparam logic [M_W-1:0]  M_BEQ    = 3'b100;
  localparam logic [M_W-1:0]  M_NOP    = 3'b000;

  localparam logic [EX_W-1:0] EX_RTYPE = 4'b1100;
  localparam logic [EX_W-1:0] EX_LW    = 4'b0001;
  localparam logic [EX_W-1:0] EX_SW    = 4'b0001;
  localparam logic [EX_W-1:0] EX_BEQ   = 4'b0010;
  localparam logic [EX_W-1:0] EX_NOP   = 4'b0000;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{wb: WB_NOP, m: M_NOP, ex: EX_NOP};

  function automatic logic [31:0] sign_extend16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage : id_pkg

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module : reg_file
// Desc   : 2R/1W register file, r0 hardwired to zero, write-through bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file
  import id_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_REGS)-1:0] raddr1_i,
  input  logic [$clog2(NUM_REGS)-1:0] raddr2_i,
  output logic [31:0]                 rdata1_o,
  output logic [31:0]                 rdata2_o,
  input  logic                        we_i,
  input  logic [$clog2(NUM_REGS)-1:0] waddr_i,
  input  logic [31:0]                 wdata_i
);

  localparam int AW = $clog2(NUM_REGS);

  logic [31:0] regs_q [NUM_REGS];
  logic        wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // The write lands at the same edge the ID/EX latch samples, so forward it.
  function automatic logic [31:0] read_port(input logic [AW-1:0] addr);
    if (addr == '0)                     return '0;
    else if (wr_en && waddr_i == addr)  return wdata_i;
    else                                return regs_q[addr];
  endfunction

  assign rdata1_o = read_port(raddr1_i);
  assign rdata2_o = read_port(raddr2_i);

endmodule : reg_file

`default_nettype wire

// File: rtl/i_decode.sv
// ============================================================================
// Module : i_decode
// Desc   : MIPS ID stage: control decode, register read, ID/EX latch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i_decode
  import id_pkg::*;
#(
  parameter int FLUSH_ON_BRANCH = 1,
  parameter int NUM_REGS        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     IF_ID_instr,
  input  logic [31:0]     IF_ID_npc,
  input  logic            EX_MEM_PCSrc,
  input  logic            MEM_WB_RegWrite,
  input  logic [4:0]      MEM_WB_WriteReg,
  input  logic [31:0]     MEM_WB_WriteData,
  output logic [WB_W-1:0] ID_EX_wb,
  output logic [M_W-1:0]  ID_EX_m,
  output logic [EX_W-1:0] ID_EX_ex,
  output logic [31:0]     ID_EX_npc,
  output logic [31:0]     ID_EX_readdat1,
  output logic [31:0]     ID_EX_readdat2,
  output logic [31:0]     ID_EX_signext,
  output logic [4:0]      ID_EX_rt,
  output logic [4:0]      ID_EX_rd
);

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rdata1, rdata2;
  logic        flush;
  ctrl_t       ctrl_d, ctrl_q;

  logic [31:0] npc_q, rd1_q, rd2_q, sext_q;
  logic [4:0]  rt_q, rd_q;

  assign opcode = IF_ID_instr[31:26];
  assign rs     = IF_ID_instr[25:21];
  assign rt     = IF_ID_instr[20:16];
  assign rd     = IF_ID_instr[15:11];
  assign flush  = (FLUSH_ON_BRANCH != 0) && EX_MEM_PCSrc;

  reg_file #(
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk      (clk),
    .reset    (reset),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2),
    .we_i     (MEM_WB_RegWrite),
    .waddr_i  (MEM_WB_WriteReg),
    .wdata_i  (MEM_WB_WriteData)
  );

  always_comb begin
    ctrl_d = CTRL_NOP;
    if (!flush) begin
      unique case (opcode)
        OP_RTYPE: ctrl_d = '{wb: WB_RTYPE, m: M_RTYPE, ex: EX_RTYPE};
        OP_LW:    ctrl_d = '{wb: WB_LW,    m: M_LW,    ex: EX_LW};
        OP_SW:    ctrl_d = '{wb: WB_SW,    m: M_SW,    ex: EX_SW};
        OP_BEQ:   ctrl_d = '{wb: WB_BEQ,   m: M_BEQ,   ex: EX_BEQ};
        default:  ctrl_d = CTRL_NOP;
      endcase
    end
  end

  // Flush only kills the control bundles; data fields keep flowing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q <= CTRL_NOP;
      npc_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      sext_q <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      npc_q  <= IF_ID_npc;
      rd1_q  <= rdata1;
      rd2_q  <= rdata2;
      sext_q <= sign_extend16(IF_ID_instr[15:0]);
      rt_q   <= rt;
      rd_q   <= rd;
    end
  end

  assign ID_EX_wb       = ctrl_q.wb;
  assign ID_EX_m        = ctrl_q.m;
  assign ID_EX_ex       = ctrl_q.ex;
  assign ID_EX_npc      = npc_q;
  assign ID_EX_readdat1 = rd1_q;
  assign ID_EX_readdat2 = rd2_q;
  assign ID_EX_signext  = sext_q;
  assign ID_EX_rt       = rt_q;
  assign ID_EX_rd       = rd_q;

endmodule : i_decode

`default_nettype wire
